// File: rtl/data_sram_bridge_pkg.sv
// Shared types for the data-side SRAM-to-request/response bus bridge.
package data_sram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/data_sram_bridge_wen_to_size.sv
// Maps SRAM byte write-enables to a bus transfer size and the lane offset of the lowest enabled byte.
module data_sram_bridge_wen_to_size
    import data_sram_bridge_pkg::*;
(
    input  logic [3:0] wen,
    output logic [1:0] size,
    output logic [1:0] lane
);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        size = SIZE_WORD;
        lane = 2'd0;

        if (wen[0])      lane = 2'd0;
        else if (wen[1]) lane = 2'd1;
        else if (wen[2]) lane = 2'd2;
        else if (wen[3]) lane = 2'd3;

        case (wen)
            4'b0011, 4'b1100:                   size = SIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
            default:                            size = SIZE_WORD;
        endcase
    end

endmodule

// File: rtl/data_sram_bridge.sv
// Data-side bridge: single-cycle SRAM port to addr_ok/data_ok request/response bus, stalling M while busy.
// Optional DBRIDGE_KSEG_MAP_EN folds kseg0/kseg1 addresses (top bits 2'b10) down to physical.
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    input  logic              cpu_stall,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata
);

    state_t            state;
    state_t            state_nx;
    logic [1:0]        wen_size;
    logic [1:0]        wen_lane;
    logic [ADDR_W-1:0] bus_addr;
    logic              launch;
    logic              resp_done;

    data_sram_bridge_wen_to_size u_wen_to_size (
        .wen  (mem_wen),
        .size (wen_size),
        .lane (wen_lane)
    );

    assign launch    = (state == IDLE) && mem_en;
    assign resp_done = ((state == REQ) && addr_ok && data_ok) || ((state == WAIT) && data_ok);

    // Reads use lane 0 because the size helper returns lane 0 for an all-zero enable.
    always_comb begin
        bus_addr      = mem_addr;
        bus_addr[1:0] = wen_lane;
`ifdef DBRIDGE_KSEG_MAP_EN
        if (mem_addr[ADDR_W-1 -: 2] == 2'b10) begin
            bus_addr[ADDR_W-1 -: 3] = 3'b000;
        end
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (mem_en) state_nx = REQ;
            REQ:     if (addr_ok) state_nx = data_ok ? DONE : WAIT;
            WAIT:    if (data_ok) state_nx = DONE;
            DONE:    if (!cpu_stall) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state and bus fields use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr        <= 1'b0;
            size      <= SIZE_BYTE;
            addr      <= '0;
            wdata     <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                wr    <= |mem_wen;
                size  <= wen_size;
                addr  <= bus_addr;
                wdata <= mem_wdata;
            end
            // Write acks leave the previously returned read word untouched.
            if (resp_done && !wr) begin
                mem_rdata <= rdata;
            end
        end
    end

    assign req       = (state == REQ);
    assign mem_stall = launch || (state == REQ) || (state == WAIT);

endmodule

// File: tb/tb_data_sram_bridge.sv
// Scoreboard bench for data_sram_bridge: stimulus queues expected bus requests and read words, monitors compare.
`timescale 1ns/1ps
module tb_data_sram_bridge;
    import data_sram_bridge_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

`ifdef DBRIDGE_KSEG_MAP_EN
    localparam logic [31:0] EXP_RD0  = 32'h0000_0104;
    localparam logic [31:0] EXP_KSEG = 32'h1FC0_0000;
`else
    localparam logic [31:0] EXP_RD0  = 32'h8000_0104;
    localparam logic [31:0] EXP_KSEG = 32'hBFC0_0000;
`endif
    localparam logic [31:0] JUNK = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en = 1'b0;
    logic [3:0]  mem_wen = 4'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        cpu_stall = 1'b0;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok = 1'b0;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = 32'd0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          stall_cnt = 0;
    logic [31:0] model_rdata = 32'd0;
    bus_req_t    req_q[$];
    logic [31:0] rsp_q[$];

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall),
        .cpu_stall (cpu_stall),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && mem_stall) stall_cnt++;
    end

    // Monitor: request fields at the addr_ok handshake, read word one edge after data_ok.
    initial begin : monitor
        bit       pending;
        bit       rsp_due;
        bus_req_t exp_req;
        logic [31:0] exp_word;
        pending = 0;
        rsp_due = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pending = 0;
                rsp_due = 0;
            end else begin
                if (rsp_due) begin
                    rsp_due = 0;
                    if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
                    else begin
                        exp_word = rsp_q.pop_front();
                        check("mem_rdata", mem_rdata, exp_word);
                    end
                end
                if (req && addr_ok) begin
                    if (req_q.size() == 0) check("req_unexpected", 1, 0);
                    else begin
                        exp_req = req_q.pop_front();
                        check("bus_wr", wr, exp_req.wr);
                        check("bus_size", size, exp_req.size);
                        check("bus_addr", addr, exp_req.addr);
                        check("bus_wdata", wdata, exp_req.wdata);
                    end
                    pending = 1;
                end
                if (pending && data_ok) begin
                    pending = 0;
                    rsp_due = 1;
                end
            end
        end
    end

    // Called at posedge+1 with the bridge idle; returns at posedge+1 with it idle again.
    task automatic access(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                          input int a_dly, input int d_dly, input logic [31:0] rd,
                          input logic [1:0] exp_size, input logic [31:0] exp_addr, input int hold);
        bus_req_t r;
        int       base;
        int       waited;
        r.wr    = (wen != 4'd0);
        r.size  = exp_size;
        r.addr  = exp_addr;
        r.wdata = wd;
        req_q.push_back(r);
        if (wen == 4'd0) model_rdata = rd;
        rsp_q.push_back(model_rdata);
        base = stall_cnt;
        mem_en = 1'b1;
        mem_wen = wen;
        mem_addr = a;
        mem_wdata = wd;
        @(posedge clk); #1;
        waited = 0;
        while (!req && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req) begin
            check("req_timeout", 0, 1);
            mem_en = 1'b0;
            return;
        end
        // Scramble the SRAM side: the bridge must hold what it latched at launch.
        mem_addr = ~a;
        mem_wdata = ~wd;
        for (int i = 0; i <= a_dly; i++) begin
            check("req_held", req, 1);
            check("addr_stable", addr, r.addr);
            check("wdata_stable", wdata, r.wdata);
            if (i < a_dly) begin
                @(posedge clk); #1;
            end
        end
        addr_ok = 1'b1;
        rdata = JUNK;
        if (d_dly == 0) begin
            data_ok = 1'b1;
            rdata = rd;
        end
        @(posedge clk); #1;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        check("req_drop", req, 0);
        if (d_dly > 0) begin
            for (int i = 1; i < d_dly; i++) begin
                @(posedge clk); #1;
            end
            data_ok = 1'b1;
            rdata = rd;
            @(posedge clk); #1;
            data_ok = 1'b0;
            rdata = JUNK;
        end
        if (hold > 0) begin
            cpu_stall = 1'b1;
            for (int i = 0; i < hold; i++) begin
                check("hold_req", req, 0);
                check("hold_stall", mem_stall, 0);
                check("hold_rdata", mem_rdata, model_rdata);
                @(posedge clk); #1;
            end
            cpu_stall = 1'b0;
        end
        check("stall_cycles", stall_cnt - base, 2 + a_dly + d_dly);
        mem_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", req, 0);
        check("rst_wr", wr, 0);
        check("rst_size", size, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_stall", mem_stall, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        access(4'b0000, 32'h8000_0104, 32'h0,         0, 0, 32'hDEAD_BEEF, SIZE_WORD, EXP_RD0,       0);
        access(4'b0100, 32'h1000_0002, 32'h00AB_0000, 3, 2, JUNK,          SIZE_BYTE, 32'h1000_0002, 0);
        access(4'b1100, 32'h1000_0010, 32'hBEEF_0000, 1, 0, JUNK,          SIZE_HALF, 32'h1000_0012, 0);
        access(4'b1111, 32'h1000_0020, 32'h1122_3344, 0, 1, JUNK,          SIZE_WORD, 32'h1000_0020, 0);
        access(4'b0110, 32'h1000_0030, 32'h00CD_EF00, 0, 0, JUNK,          SIZE_WORD, 32'h1000_0031, 0);
        access(4'b1000, 32'h1000_0040, 32'h9900_0000, 0, 0, JUNK,          SIZE_BYTE, 32'h1000_0043, 0);
        access(4'b0011, 32'h1000_0053, 32'h0000_BEEF, 0, 0, JUNK,          SIZE_HALF, 32'h1000_0050, 0);
        access(4'b0000, 32'h0000_0100, 32'h0,         2, 3, 32'hA5A5_0F0F, SIZE_WORD, 32'h0000_0100, 0);
        access(4'b0000, 32'h0000_0200, 32'h0,         0, 0, 32'h1234_5678, SIZE_WORD, 32'h0000_0200, 5);
        access(4'b0000, 32'h0000_0300, 32'h0,         0, 0, 32'hCAFE_F00D, SIZE_WORD, 32'h0000_0300, 0);

        // A stray data_ok while idle must not disturb anything.
        data_ok = 1'b1;
        rdata = 32'h7777_7777;
        @(posedge clk); #1;
        data_ok = 1'b0;
        check("idle_dataok_rdata", mem_rdata, 32'hCAFE_F00D);
        check("idle_dataok_req", req, 0);

        // Abandon a read in WAIT with an asynchronous reset.
        req_q.push_back('{wr: 1'b0, size: SIZE_WORD, addr: 32'h0000_0400, wdata: 32'h0});
        mem_en = 1'b1;
        mem_wen = 4'd0;
        mem_addr = 32'h0000_0400;
        mem_wdata = 32'h0;
        @(posedge clk); #1;
        check("rstop_req_up", req, 1);
        addr_ok = 1'b1;
        @(posedge clk); #1;
        addr_ok = 1'b0;
        check("rstop_wait_stall", mem_stall, 1);
        #2;
        rst = 1'b0;
        mem_en = 1'b0;
        #1;
        check("rstop_req", req, 0);
        check("rstop_mem_rdata", mem_rdata, 0);
        check("rstop_stall", mem_stall, 0);
        check("rstop_addr", addr, 0);
        model_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        access(4'b0000, 32'hBFC0_0000, 32'h0, 0, 0, 32'h0BAD_C0DE, SIZE_WORD, EXP_KSEG, 0);

        repeat (3) @(posedge clk);
        #1;
        check("req_q_drained", req_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
